// File: rtl/arm_pkg.sv
// Shared definitions for the ARM-style pipeline: ALU command encodings,
// the decode control word and default datapath widths.
package arm_pkg;

    localparam int DEF_WORD_W  = 32;
    localparam int DEF_REG_W   = 4;
    localparam int EXE_CMD_W   = 4;
    localparam int SHIFT_OP_W  = 12;
    localparam int SIGNED_IMM_W = 24;

    // ALU command encodings; 0000 is the bubble/no-op value.
    typedef enum logic [EXE_CMD_W-1:0] {
        EXE_NOP = 4'b0000,
        EXE_MOV = 4'b0001,
        EXE_MVN = 4'b1001,
        EXE_ADD = 4'b0010,
        EXE_ADC = 4'b0011,
        EXE_SUB = 4'b0100,
        EXE_SBC = 4'b0101,
        EXE_AND = 4'b0110,
        EXE_ORR = 4'b0111,
        EXE_EOR = 4'b1000
    } exe_cmd_e;

    // Control word produced by the decode control unit.
    typedef struct packed {
        logic     wb_en;
        logic     mem_r_en;
        logic     mem_w_en;
        logic     b;
        logic     s;
        exe_cmd_e exe_cmd;
    } ctrl_word_t;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: async active-low reset, load enable and a
// synchronous clear that only takes effect on an enabled edge.
module pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Capture, clear or hold the stored word on each rising edge.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: every bit here is a pipeline flop, so all of it is reset;
        // non-blocking assignments keep the edge semantics race-free.
        if (!rst) begin
            r_q <= '0;
        end else if (en) begin
            if (clr) begin
                r_q <= '0;
            end else begin
                r_q <= i_d;
            end
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register. Holds the decoded control word, operands and
// PC for the execute stage, with stall (freeze), bubble insertion (flush)
// and a valid tag. Control bits are cleared for any bubble so that
// valid_out = 0 always implies no write-back, memory access or flag update.
module id_exe_stage_reg
    import arm_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    freeze,
    input  logic                    flush,
    input  logic                    valid_in,
    input  logic                    WB_EN_in,
    input  logic                    MEM_R_EN_in,
    input  logic                    MEM_W_EN_in,
    input  logic                    B_in,
    input  logic                    S_in,
    input  logic [EXE_CMD_W-1:0]    EXE_CMD_in,
    input  logic [WORD_W-1:0]       PC_in,
    input  logic [WORD_W-1:0]       Val_Rn_in,
    input  logic [WORD_W-1:0]       Val_Rm_in,
    input  logic                    imm_in,
    input  logic [SHIFT_OP_W-1:0]   Shift_operand_in,
    input  logic [SIGNED_IMM_W-1:0] Signed_imm_24_in,
    input  logic [REG_W-1:0]        Dest_in,
    input  logic [REG_W-1:0]        Src1_in,
    input  logic [REG_W-1:0]        Src2_in,
    input  logic                    C_in,
    output logic                    valid_out,
    output logic                    WB_EN_out,
    output logic                    MEM_R_EN_out,
    output logic                    MEM_W_EN_out,
    output logic                    B_out,
    output logic                    S_out,
    output logic [EXE_CMD_W-1:0]    EXE_CMD_out,
    output logic [WORD_W-1:0]       PC_out,
    output logic [WORD_W-1:0]       Val_Rn_out,
    output logic [WORD_W-1:0]       Val_Rm_out,
    output logic                    imm_out,
    output logic [SHIFT_OP_W-1:0]   Shift_operand_out,
    output logic [SIGNED_IMM_W-1:0] Signed_imm_24_out,
    output logic [REG_W-1:0]        Dest_out,
    output logic [REG_W-1:0]        Src1_out,
    output logic [REG_W-1:0]        Src2_out,
    output logic                    C_out
);

    // Valid tag travels with the control word so one clear kills both.
    localparam int CTRL_W = 1 + $bits(ctrl_word_t);
    localparam int DATA_W = 3 * WORD_W + 1 + SHIFT_OP_W + SIGNED_IMM_W + 3 * REG_W + 1;

    logic              w_load_en;
    logic              w_ctrl_clr;
    ctrl_word_t        w_ctrl_in;
    ctrl_word_t        w_ctrl_q;
    logic              w_valid_q;
    logic [CTRL_W-1:0] w_ctrl_d_bus;
    logic [CTRL_W-1:0] w_ctrl_q_bus;
    logic [DATA_W-1:0] w_data_d;
    logic [DATA_W-1:0] w_data_q;

    // Flush must override freeze, so it also forces the enable.
    assign w_load_en  = !freeze || flush;
    // A non-valid instruction loads its datapath but never its control bits.
    assign w_ctrl_clr = flush || !valid_in;

    assign w_ctrl_in = '{
        wb_en:    WB_EN_in,
        mem_r_en: MEM_R_EN_in,
        mem_w_en: MEM_W_EN_in,
        b:        B_in,
        s:        S_in,
        exe_cmd:  exe_cmd_e'(EXE_CMD_in)
    };

    assign w_ctrl_d_bus = {valid_in, w_ctrl_in};

    pipe_reg #(.WIDTH(CTRL_W)) u_ctrl_reg (
        .clk (clk),
        .rst (rst),
        .clr (w_ctrl_clr),
        .en  (w_load_en),
        .i_d (w_ctrl_d_bus),
        .o_q (w_ctrl_q_bus)
    );

    assign {w_valid_q, w_ctrl_q} = w_ctrl_q_bus;

    assign valid_out    = w_valid_q;
    assign WB_EN_out    = w_ctrl_q.wb_en;
    assign MEM_R_EN_out = w_ctrl_q.mem_r_en;
    assign MEM_W_EN_out = w_ctrl_q.mem_w_en;
    assign B_out        = w_ctrl_q.b;
    assign S_out        = w_ctrl_q.s;
    assign EXE_CMD_out  = w_ctrl_q.exe_cmd;

    // Datapath fields are passed bit-exact; sign extension happens in EXE.
    assign w_data_d = {PC_in, Val_Rn_in, Val_Rm_in, imm_in, Shift_operand_in,
                       Signed_imm_24_in, Dest_in, Src1_in, Src2_in, C_in};

    pipe_reg #(.WIDTH(DATA_W)) u_data_reg (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .en  (w_load_en),
        .i_d (w_data_d),
        .o_q (w_data_q)
    );

    assign {PC_out, Val_Rn_out, Val_Rm_out, imm_out, Shift_operand_out,
            Signed_imm_24_out, Dest_out, Src1_out, Src2_out, C_out} = w_data_q;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Self-checking bench for id_exe_stage_reg: directed scenarios followed by
// randomized traffic, all compared against a field-level reference model.
module tb_id_exe_stage_reg;
    import arm_pkg::*;

    localparam int WW = DEF_WORD_W;
    localparam int RW = DEF_REG_W;

    // One record holding every field of the stage, inputs or outputs alike.
    typedef struct packed {
        logic          valid;
        logic          wb_en;
        logic          mem_r_en;
        logic          mem_w_en;
        logic          b;
        logic          s;
        logic [3:0]    exe_cmd;
        logic [WW-1:0] pc;
        logic [WW-1:0] val_rn;
        logic [WW-1:0] val_rm;
        logic          imm;
        logic [11:0]   shift_op;
        logic [23:0]   simm;
        logic [RW-1:0] dest;
        logic [RW-1:0] src1;
        logic [RW-1:0] src2;
        logic          c;
    } bundle_t;

    logic    clk    = 1'b0;
    logic    rst    = 1'b0;
    logic    freeze = 1'b0;
    logic    flush  = 1'b0;
    bundle_t stim   = '0;
    bundle_t exp_q  = '0;
    bundle_t obs;
    int      n_tests = 0;
    int      n_fail  = 0;

    logic          valid_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out;
    logic [3:0]    EXE_CMD_out;
    logic [WW-1:0] PC_out, Val_Rn_out, Val_Rm_out;
    logic          imm_out, C_out;
    logic [11:0]   Shift_operand_out;
    logic [23:0]   Signed_imm_24_out;
    logic [RW-1:0] Dest_out, Src1_out, Src2_out;

    id_exe_stage_reg #(.WORD_W(WW), .REG_W(RW)) dut (
        .clk               (clk),
        .rst               (rst),
        .freeze            (freeze),
        .flush             (flush),
        .valid_in          (stim.valid),
        .WB_EN_in          (stim.wb_en),
        .MEM_R_EN_in       (stim.mem_r_en),
        .MEM_W_EN_in       (stim.mem_w_en),
        .B_in              (stim.b),
        .S_in              (stim.s),
        .EXE_CMD_in        (stim.exe_cmd),
        .PC_in             (stim.pc),
        .Val_Rn_in         (stim.val_rn),
        .Val_Rm_in         (stim.val_rm),
        .imm_in            (stim.imm),
        .Shift_operand_in  (stim.shift_op),
        .Signed_imm_24_in  (stim.simm),
        .Dest_in           (stim.dest),
        .Src1_in           (stim.src1),
        .Src2_in           (stim.src2),
        .C_in              (stim.c),
        .valid_out         (valid_out),
        .WB_EN_out         (WB_EN_out),
        .MEM_R_EN_out      (MEM_R_EN_out),
        .MEM_W_EN_out      (MEM_W_EN_out),
        .B_out             (B_out),
        .S_out             (S_out),
        .EXE_CMD_out       (EXE_CMD_out),
        .PC_out            (PC_out),
        .Val_Rn_out        (Val_Rn_out),
        .Val_Rm_out        (Val_Rm_out),
        .imm_out           (imm_out),
        .Shift_operand_out (Shift_operand_out),
        .Signed_imm_24_out (Signed_imm_24_out),
        .Dest_out          (Dest_out),
        .Src1_out          (Src1_out),
        .Src2_out          (Src2_out),
        .C_out             (C_out)
    );

    assign obs = {valid_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out,
                  EXE_CMD_out, PC_out, Val_Rn_out, Val_Rm_out, imm_out,
                  Shift_operand_out, Signed_imm_24_out, Dest_out, Src1_out,
                  Src2_out, C_out};

    always #5 clk = ~clk;

    // Reference behaviour of one clock edge: flush beats freeze beats load;
    // a non-valid load keeps its data but carries no control.
    function automatic bundle_t model_next(bundle_t cur, bundle_t in, logic fl, logic fr);
        bundle_t n;
        if (fl) return '0;
        if (fr) return cur;
        n = in;
        if (!in.valid) begin
            n.wb_en    = 1'b0;
            n.mem_r_en = 1'b0;
            n.mem_w_en = 1'b0;
            n.b        = 1'b0;
            n.s        = 1'b0;
            n.exe_cmd  = 4'b0000;
        end
        return n;
    endfunction

    function automatic bundle_t rand_bundle();
        bundle_t r;
        r.valid    = ($urandom_range(3) != 0);
        r.wb_en    = 1'($urandom);
        r.mem_r_en = 1'($urandom);
        r.mem_w_en = 1'($urandom);
        r.b        = 1'($urandom);
        r.s        = 1'($urandom);
        r.exe_cmd  = 4'($urandom);
        r.pc       = WW'($urandom);
        r.val_rn   = WW'($urandom);
        r.val_rm   = WW'($urandom);
        r.imm      = 1'($urandom);
        r.shift_op = 12'($urandom);
        r.simm     = 24'($urandom);
        r.dest     = RW'($urandom);
        r.src1     = RW'($urandom);
        r.src2     = RW'($urandom);
        r.c        = 1'($urandom);
        return r;
    endfunction

    // Directed instruction: random operands with the named control fields.
    function automatic bundle_t instr(logic [3:0] cmd, logic wb, logic mr, logic mw,
                                      logic s, logic [WW-1:0] pc, logic [RW-1:0] dest);
        bundle_t r;
        r          = rand_bundle();
        r.valid    = 1'b1;
        r.exe_cmd  = cmd;
        r.wb_en    = wb;
        r.mem_r_en = mr;
        r.mem_w_en = mw;
        r.b        = 1'b0;
        r.s        = s;
        r.pc       = pc;
        r.dest     = dest;
        return r;
    endfunction

    // Advance one edge: update the model with what the DUT samples, then
    // move to the falling edge where outputs are compared.
    task automatic tick();
        @(posedge clk);
        exp_q = model_next(exp_q, stim, flush, freeze);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input bundle_t o, input bundle_t e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Full comparison plus the bubble-masking invariant on the live outputs.
    task automatic check_all(input string tag);
        check(tag, obs, exp_q);
        check32({tag, "_mask"},
                32'(valid_out ? 5'b0 : {WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out}),
                32'd0);
    endtask

    initial begin
        // Reset state.
        rst = 1'b0;
        @(negedge clk);
        exp_q = '0;
        check_all("reset");

        // ADD load, then asynchronous reset between edges.
        rst  = 1'b1;
        stim = instr(EXE_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 4'd1);
        tick();
        check_all("add_load");
        #1 rst = 1'b0;
        #1 exp_q = '0;
        check_all("rst_mid");
        check32("rst_mid_pc", PC_out, 32'd0);
        #1 rst = 1'b1;
        stim = instr(EXE_ORR, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0014, 4'd2);
        tick();
        check_all("rst_release");

        // Normal flow: MOV, SUB, STR.
        stim = instr(EXE_MOV, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0020, 4'd3);
        tick();
        check_all("mov");
        stim = instr(EXE_SUB, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0024, 4'd4);
        tick();
        check_all("sub");
        stim = instr(EXE_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0028, 4'd0);
        tick();
        check_all("str");
        check32("str_valid", 32'(valid_out), 32'd1);

        // Freeze holds the LDR across three cycles of changing inputs.
        stim = instr(EXE_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_002C, 4'd5);
        tick();
        check_all("ldr_load");
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stim = rand_bundle();
            tick();
            check_all("freeze_hold");
            check32("freeze_dest", 32'(Dest_out), 32'd5);
        end
        freeze = 1'b0;
        stim   = instr(EXE_EOR, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0030, 4'd6);
        tick();
        check_all("freeze_release");

        // Flush beats freeze while a CMP is held.
        stim = instr(EXE_SUB, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0034, 4'd0);
        tick();
        check_all("cmp_load");
        freeze = 1'b1;
        flush  = 1'b1;
        stim   = rand_bundle();
        tick();
        check_all("flush_freeze");
        check32("flush_pc", PC_out, 32'd0);
        freeze = 1'b0;
        flush  = 1'b0;

        // Single flush cycle gives exactly one bubble.
        stim  = instr(EXE_ADC, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0038, 4'd7);
        flush = 1'b1;
        tick();
        check_all("flush_one");
        flush = 1'b0;
        tick();
        check_all("after_flush");

        // Bubble masking with control bits asserted on a non-valid slot.
        stim          = rand_bundle();
        stim.valid    = 1'b0;
        stim.wb_en    = 1'b1;
        stim.mem_w_en = 1'b1;
        stim.b        = 1'b1;
        stim.val_rn   = 32'hDEAD_BEEF;
        tick();
        check_all("bubble_mask");
        check32("bubble_rn", Val_Rn_out, 32'hDEAD_BEEF);

        // Field integrity, no sign extension.
        stim          = instr(EXE_MVN, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_003C, 4'd8);
        stim.b        = 1'b1;
        stim.simm     = 24'hFF_FFFE;
        stim.shift_op = 12'hABC;
        stim.c        = 1'b1;
        tick();
        check_all("fields");
        check32("fields_simm", 32'(Signed_imm_24_out), 32'h00FF_FFFE);

        // Randomized traffic with random freeze/flush.
        for (int i = 0; i < 300; i++) begin
            freeze = ($urandom_range(3) == 0);
            flush  = ($urandom_range(7) == 0);
            stim   = rand_bundle();
            tick();
            check_all("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_exe_stage_reg.md
# id_exe_stage_reg

Pipeline register between Instruction Decode and Execute. Captures the control word from the decode control unit, the decoded operands and the PC on every rising clock edge. Supports freeze (hazard stall), flush (branch-taken bubble insertion) and a valid tag so downstream stages can ignore bubbles. All outputs are registered and feed the EXE stage ALU, branch adder and status logic directly.

## Interface

**Parameters**
- `WORD_W`, default 32: datapath width for PC and register values.
- `REG_W`, default 4: register-index width.

**Ports**
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: asynchronous, active-low reset.
- `freeze`, input, 1: hold all outputs (hazard stall).
- `flush`, input, 1: load a bubble (branch taken in EXE).
- `valid_in`, input, 1: ID holds a real instruction.
- `WB_EN_in`, `MEM_R_EN_in`, `MEM_W_EN_in`, `B_in`, `S_in`, input, 1 each: control bits from the control unit.
- `EXE_CMD_in`, input, 4: ALU command.
- `PC_in`, input, WORD_W: PC+4 of the instruction.
- `Val_Rn_in`, `Val_Rm_in`, input, WORD_W: register-file read data.
- `imm_in`, input, 1: immediate-operand flag.
- `Shift_operand_in`, input, 12: shifter operand field.
- `Signed_imm_24_in`, input, 24: branch offset.
- `Dest_in`, `Src1_in`, `Src2_in`, input, REG_W: destination and source indices (Src kept for forwarding).
- `C_in`, input, 1: current status-register carry.
- Outputs: one `*_out` for each `*_in` above with identical width, plus `valid_out`, 1.

## Operation

- **Reset** (`rst` = 0, asynchronous): every output is 0, including `valid_out`, `EXE_CMD_out` = 4'b0000 and `PC_out` = 0. Reset asserted mid-operation discards the held instruction immediately, without waiting for a clock edge.
- **Priority per edge**, highest first:
  - flush: all control outputs (`WB_EN`, `MEM_R_EN`, `MEM_W_EN`, `B`, `S`) = 0, `EXE_CMD_out` = 0, `valid_out` = 0. Datapath fields (PC, Val_*, imm, Shift_operand, Signed_imm_24, Dest, Src*, C) also clear to 0.
  - freeze: all outputs hold their previous values.
  - normal: every `*_out` ← `*_in`; `valid_out` ← `valid_in`.
- **flush and freeze together**: flush wins. A taken branch must kill the frozen instruction.
- **valid_in = 0 under normal load**: datapath is captured as-is, but all control outputs are forced to 0. This guarantees no write-back, memory access or flag update.
- **Bubble masking**: `valid_out` = 0 implies `WB_EN_out` = `MEM_R_EN_out` = `MEM_W_EN_out` = `B_out` = `S_out` = 0. This invariant holds in every state.
- **Widths**: no arithmetic; all fields are passed bit-exact with no sign extension. Sign extension of `Signed_imm_24` belongs to EXE.

## Timing

- Latency is 1 cycle: an input sampled at edge N appears on the outputs after edge N.
- No combinational path from any input to any output.
- `freeze` and `flush` are sampled on the same edge as the data they act on.
- Freeze is held for an arbitrary number of cycles; outputs stay stable across all of them.
- The first edge after freeze deasserts loads the current inputs.
- `flush` for one cycle produces exactly one bubble cycle.
- Reset release: the first rising edge with `rst` = 1 performs a normal load.

## Structure

- Shared package `arm_pkg`:
  - `EXE_CMD` encodings: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000.
  - Control-word struct: WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD.
  - `WORD_W` and `REG_W` defaults.
- Sub-module `pipe_reg`: a parameterised-width register with async active-low reset, `clr` (synchronous clear) and `en` (load enable). Instantiate it once for the control word and once for the concatenated datapath bundle. Mapping:
  - `clr` = flush, or (for the control instance only) `!valid_in` on load.
  - `en` = `!freeze || flush`.

## Test plan

- **Reset mid-operation**: load ADD (`EXE_CMD` 0010, `WB_EN` 1, `PC` 0x0000_0010). Pulse `rst` low between edges → all outputs read 0 before the next edge. The first edge after release loads the current inputs.
- **Normal flow**: drive MOV, SUB, STR on consecutive cycles (`EXE_CMD` 0001/0100/0010, `MEM_W_EN` 0/0/1) → outputs match each input exactly one cycle later, with `valid_out` = 1.
- **Freeze**: hold `freeze` = 1 for 3 cycles while the inputs change → outputs keep the pre-freeze LDR (`MEM_R_EN` 1, `Dest` 4'd5) for all 3 cycles. The next instruction appears one cycle after release.
- **Flush priority**: assert `flush` and `freeze` together with a CMP held (`S_out` 1) → next cycle all control outputs are 0, `valid_out` = 0 and `PC_out` = 0.
- **Bubble masking**: `valid_in` = 0 with `WB_EN_in` = `MEM_W_EN_in` = `B_in` = 1 → all control outputs are 0 and `Val_Rn_out` still equals `Val_Rn_in` (0xDEAD_BEEF).
- **Field integrity**: `Signed_imm_24_in` = 0xFFFFFE, `Shift_operand_in` = 0xABC, `C_in` = 1 → outputs match bit-exact, with no sign extension.
